cv32e40p_obi_mem_responder: RTL and testbench

- Responder (memory) end of the core's OBI-style instruction/data request channel (req/gnt/rvalid, in-order responses).
- Single-port word-addressed SRAM model with programmable grant and response back-pressure.
- Serves as data or instruction memory for core-level simulation, and as a reusable responder for verifying the core's LSU and prefetcher.
- Commits writes and samples read data at grant; returns responses strictly in grant order through an outstanding-response FIFO.

---
 rtl/cv32e40p_obi_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// cv32e40p_obi_mem_responder
//
// Memory (responder) end of an OBI-style req/gnt/rvalid channel. The memory is
// a single-port, word-addressed SRAM model. Grant and response back-pressure
// can be programmed for testing. Writes are committed at the grant edge. Read
// data is sampled at the grant edge. Responses come back strictly in grant
// order through a small outstanding-response FIFO.
//
// Handshake semantics:
//   - A transaction is accepted on a rising edge where req_i && gnt_o.
//   - gnt_o is combinational and may assert in the same cycle req_i rises.
//     The initiator holds req/addr/we/be/wdata stable until it is granted.
//   - Every accepted transaction produces exactly one rvalid_o pulse, one
//     cycle or more later, in acceptance order. rvalid_o has no ready:
//     the initiator must always accept a response.
//
// Ports:
//   clk_i, rst_i      clock; asynchronous active-high reset
//   req_i, gnt_o      request valid in / combinational grant out
//   addr_i            byte address (word index = addr_i[AW+1:2], upper bits wrap)
//   we_i, be_i        write enable / byte enables (be_i applies to writes only)
//   wdata_i           write data
//   rvalid_o, rdata_o registered response pulse and data (0 for writes)
//   gnt_stall_i       forces gnt_o low while set
//   resp_stall_i      holds responses in the FIFO while set
//   outstanding_o     registered count of granted-but-unanswered transactions
// -----------------------------------------------------------------------------
module cv32e40p_obi_mem_responder #(
    parameter int MEM_WORDS       = 1024,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        gnt_stall_i,
    input  logic        resp_stall_i,
    output logic [3:0]  outstanding_o
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0]    MAX_CNT  = 4'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    // Storage. Neither array is reset: memory contents survive reset, and
    // FIFO slots are meaningless once the pointers and count are cleared.
    logic [31:0] mem_q  [MEM_WORDS];
    logic [31:0] fifo_q [MAX_OUTSTANDING];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic [31:0]   mem_wdata_d;
    logic [31:0]   push_data;
    logic          fifo_empty;
    logic          head_avail;
    logic [31:0]   head_data;
    logic          pop;
    logic          push_fifo;
    logic          pop_fifo;
    logic          mem_we;

    // The byte offset and the address bits above the memory are
    // intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

    assign idx     = addr_i[AW+1:2];
    assign rd_word = mem_q[idx];

    // The grant never uses credit from a pop in the same cycle, so a full
    // FIFO blocks the grant even while it is draining.
    assign gnt_o = req_i & ~gnt_stall_i & (count_q < MAX_CNT) & ~rst_i;

    assign mem_we = gnt_o & we_i;

    // Write merge: lanes with be_i set take new data, the others keep rd_word.
    always_comb begin
        mem_wdata_d = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (be_i[b]) begin
                mem_wdata_d[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // A read returns the word as it is before this edge's write. Only one
    // transaction is granted per cycle, so the read and write cannot collide.
    assign push_data = we_i ? 32'h0 : rd_word;

    assign fifo_empty = (count_q == 4'd0);

    // An empty FIFO with a grant this cycle presents the new entry directly
    // (bypass). This gives a 1-cycle latency without a FIFO round trip.
    assign head_avail = ~fifo_empty | gnt_o;
    assign head_data  = fifo_empty ? push_data : fifo_q[rd_ptr_q];
    assign pop        = head_avail & ~resp_stall_i;

    // A bypassed entry never touches the FIFO storage or pointers.
    assign push_fifo = gnt_o & ~(fifo_empty & pop);
    assign pop_fifo  = pop & ~fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        // Explicit wrap compare, so depths that are not a power of two work.
        if (push_fifo) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_fifo) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push_fifo, pop_fifo})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            rvalid_d = 1'b1;
            rdata_d  = head_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[idx] <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_fifo) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign outstanding_o = count_q;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
module tb_cv32e40p_obi_mem_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] addr_i = '0;
  logic        we_i = 1'b0;
  logic [3:0]  be_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        gnt_stall_i = 1'b0;
  logic        resp_stall_i = 1'b0;
  logic [3:0]  outstanding_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  cv32e40p_obi_mem_responder #(
    .MEM_WORDS(1024),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_i(req_i),
    .gnt_o(gnt_o),
    .addr_i(addr_i),
    .we_i(we_i),
    .be_i(be_i),
    .wdata_i(wdata_i),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .gnt_stall_i(gnt_stall_i),
    .resp_stall_i(resp_stall_i),
    .outstanding_o(outstanding_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each response must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) check("mon_unexpected_rvalid", 32'd1, 32'd0);
      else check("mon_rdata", rdata_o, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Driver: called at posedge+1, returns at posedge+1 after the granting edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata);
    bit granted = 1'b0;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (gnt_o === 1'b1) begin
        granted = 1'b1;
        exp_q.push_back(exp_rdata);
      end
      tick();
      if (granted) break;
    end
    req_i = 1'b0; we_i = 1'b0;
    if (!granted) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  // Unstalled transfer: response must appear exactly one cycle after grant.
  task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata);
    issue(we, addr, be, wdata, exp_rdata);
    check({tag, "_rvalid"}, {31'd0, rvalid_o}, 32'd1);
    check({tag, "_rdata"}, rdata_o, exp_rdata);
  endtask

  initial begin
    // reset state, with a request pending: grant must be held low in reset
    req_i = 1'b1;
    repeat (3) tick();
    check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_outstanding", {28'd0, outstanding_o}, 32'd0);
    check("rst_gnt", {31'd0, gnt_o}, 32'd0);
    req_i = 1'b0;
    rst_i = 1'b0;
    tick();

    // write then read, no stalls
    xfer("wr10", 1'b1, 32'h0000_0010, 4'hF, 32'hCAFE_F00D, 32'h0);
    check("wr10_outstanding", {28'd0, outstanding_o}, 32'd0);
    xfer("rd10", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'hCAFE_F00D);
    tick();
    check("rd10_pulse_end", {31'd0, rvalid_o}, 32'd0);

    // byte enables
    xfer("be_pre", 1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0);
    xfer("be_wr", 1'b1, 32'h0000_0010, 4'b0101, 32'hAABB_CCDD, 32'h0);
    xfer("be_rd", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h11BB_33DD);

    // preload words 0,1,2
    xfer("pre0", 1'b1, 32'h0, 4'hF, 32'd1, 32'h0);
    xfer("pre1", 1'b1, 32'h4, 4'hF, 32'd2, 32'h0);
    xfer("pre2", 1'b1, 32'h8, 4'hF, 32'd3, 32'h0);
    tick();

    // response back-pressure, FIFO fills at 2
    resp_stall_i = 1'b1;
    issue(1'b0, 32'h0, 4'h0, 32'h0, 32'd1);
    check("bp_rv0", {31'd0, rvalid_o}, 32'd0);
    check("bp_out1", {28'd0, outstanding_o}, 32'd1);
    issue(1'b0, 32'h4, 4'h0, 32'h0, 32'd2);
    check("bp_out2", {28'd0, outstanding_o}, 32'd2);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8;
    #1;
    check("bp_full_gnt", {31'd0, gnt_o}, 32'd0);
    tick();
    check("bp_full_out", {28'd0, outstanding_o}, 32'd2);
    check("bp_full_rv", {31'd0, rvalid_o}, 32'd0);
    resp_stall_i = 1'b0;
    #1;
    check("bp_no_same_cycle_credit", {31'd0, gnt_o}, 32'd0);
    tick();
    check("bp_r1_rv", {31'd0, rvalid_o}, 32'd1);
    check("bp_r1_data", rdata_o, 32'd1);
    check("bp_r1_out", {28'd0, outstanding_o}, 32'd1);
    #1;
    check("bp_gnt3", {31'd0, gnt_o}, 32'd1);
    if (gnt_o === 1'b1) exp_q.push_back(32'd3);
    tick();
    req_i = 1'b0;
    check("bp_r2_rv", {31'd0, rvalid_o}, 32'd1);
    check("bp_r2_data", rdata_o, 32'd2);
    check("bp_r2_out", {28'd0, outstanding_o}, 32'd1);
    tick();
    check("bp_r3_rv", {31'd0, rvalid_o}, 32'd1);
    check("bp_r3_data", rdata_o, 32'd3);
    check("bp_r3_out", {28'd0, outstanding_o}, 32'd0);
    tick();
    check("bp_idle_rv", {31'd0, rvalid_o}, 32'd0);

    // grant stall
    gnt_stall_i = 1'b1;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("gs_gnt", {31'd0, gnt_o}, 32'd0);
      check("gs_rv", {31'd0, rvalid_o}, 32'd0);
      check("gs_out", {28'd0, outstanding_o}, 32'd0);
      tick();
    end
    gnt_stall_i = 1'b0;
    #1;
    check("gs_release_gnt", {31'd0, gnt_o}, 32'd1);
    if (gnt_o === 1'b1) exp_q.push_back(32'd1);
    tick();
    req_i = 1'b0;
    check("gs_rv_after", {31'd0, rvalid_o}, 32'd1);
    check("gs_rdata_after", rdata_o, 32'd1);

    // address wrap
    xfer("wrap_wr", 1'b1, 32'h0000_1000, 4'hF, 32'h5A5A_5A5A, 32'h0);
    xfer("wrap_rd", 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h5A5A_5A5A);
    tick();

    // reset mid-operation
    resp_stall_i = 1'b1;
    issue(1'b0, 32'h4, 4'h0, 32'h0, 32'd2);
    issue(1'b0, 32'h8, 4'h0, 32'h0, 32'd3);
    check("mr_out_before", {28'd0, outstanding_o}, 32'd2);
    rst_i = 1'b1;
    resp_stall_i = 1'b0;
    exp_q.delete();
    #1;
    check("mr_rv_async", {31'd0, rvalid_o}, 32'd0);
    check("mr_out_async", {28'd0, outstanding_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_rv_after", {31'd0, rvalid_o}, 32'd0);
      check("mr_out_after", {28'd0, outstanding_o}, 32'd0);
    end
    xfer("mr_mem10", 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h11BB_33DD);
    xfer("mr_mem0", 1'b0, 32'h0000_0000, 4'h0, 32'h0, 32'h5A5A_5A5A);
    xfer("mr_mem4", 1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'd2);
    tick();
    tick();
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
